// File: rtl/pipe_skid_reg.sv
// Two-entry skid register stage. The main register always drives the output.
// The skid register catches the one beat that arrives while the downstream
// side is stalled. Because in_ready_o comes only from registered state,
// the upstream ready path is fully registered. A saturating counter records
// how many cycles the stage spent back-pressured.
module pipe_skid_reg #(
    parameter int                 DATA_W  = 64,
    parameter int                 CNT_W   = 32,
    parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    input  logic              flush_i,
    input  logic              cnt_clr_i,
    output logic [1:0]        occupancy_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    // The state encoding is the occupancy itself, so it can be exported directly.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] main_q, skid_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              in_fire, out_fire, stalled;

    assign in_fire  = in_valid_i & in_ready_o;
    assign out_fire = out_valid_o & out_ready_i;
    assign stalled  = out_valid_o & ~out_ready_i;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= EMPTY;
        else      state <= state_nxt;
    end

    // Next-state logic; flush overrides every handshake
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (in_fire) state_nxt = ONE;
            ONE: begin
                if (in_fire && !out_fire)      state_nxt = FULL;
                else if (!in_fire && out_fire) state_nxt = EMPTY;
            end
            FULL:    if (out_fire) state_nxt = ONE;
            default: state_nxt = EMPTY;
        endcase
        if (flush_i) state_nxt = EMPTY;
    end

    // Output decode from registered state only (no out_ready_i -> in_ready_o path)
    always_comb begin
        in_ready_o  = (state != FULL);
        out_valid_o = (state != EMPTY);
        occupancy_o = state;
    end

    // Payload registers load only on their fire conditions; a flushed beat is never stored
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_q <= RST_VAL;
            skid_q <= RST_VAL;
        end else if (!flush_i) begin
            case (state)
                EMPTY: if (in_fire) main_q <= in_data_i;
                ONE: begin
                    if (in_fire && out_fire) main_q <= in_data_i;
                    else if (in_fire)        skid_q <= in_data_i;
                end
                FULL:    if (out_fire) main_q <= skid_q;
                default: ;
            endcase
        end
    end

    assign out_data_o = main_q;

    // Saturating stall counter; clear beats increment, flush is ignored
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                       cnt_q <= '0;
        else if (cnt_clr_i)             cnt_q <= '0;
        else if (stalled && !(&cnt_q))  cnt_q <= cnt_q + 1'b1;
    end

    assign stall_cnt_o = cnt_q;

endmodule
